// File: rtl/despachador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : despachador_pkg
// Description : Shared definitions for the job dispatcher: FSM state
//               encoding, result field widths and the hash bit slice that is
//               compared against the job target.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package despachador_pkg;

  // Dispatcher FSM states
  localparam logic [1:0] INACTIVO = 2'd0;
  localparam logic [1:0] ESPERA   = 2'd1;
  localparam logic [1:0] ENTREGA  = 2'd2;
  localparam logic [1:0] PAUSA    = 2'd3;

  // Result field widths
  localparam int ANCHO_HASH   = 24;
  localparam int ANCHO_TARGET = 8;
  localparam int ANCHO_BLOQUE = 96;

  // Slice of the hash that is compared against the target
  localparam int HASH_MSB = 23;
  localparam int HASH_LSB = 16;

  // Unsigned check: the leading hash byte must be strictly below the target
  function automatic logic hash_cumple(input logic [ANCHO_HASH-1:0]   h,
                                       input logic [ANCHO_TARGET-1:0] t);
    return h[HASH_MSB:HASH_LSB] < t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_trabajo.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_trabajo
// Description : Loadable, clearable up-counter that flags "vencido" when the
//               count reaches LIMITE-1. LIMITE = 0 disables the flag.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               limpiar           - clear count to zero (highest priority)
//               cargar/valor_carga- load an arbitrary count
//               habilitar         - increment by one this cycle
//               cuenta            - current count
//               vencido           - count has reached LIMITE-1
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_trabajo #(
  parameter int               ANCHO  = 16,
  parameter logic [ANCHO-1:0] LIMITE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             limpiar,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor_carga,
  input  logic             habilitar,
  output logic [ANCHO-1:0] cuenta,
  output logic             vencido
);

  localparam logic [ANCHO-1:0] c_ultimo = LIMITE - ANCHO'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (limpiar) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= valor_carga;
    end else if (habilitar) begin
      cuenta <= cuenta + ANCHO'(1);
    end
  end

  assign vencido = (LIMITE != '0) && (cuenta == c_ultimo);

endmodule
`default_nettype wire

// File: rtl/despachador_trabajos.sv
`default_nettype none
// ============================================================================
// Module      : despachador_trabajos
// Description : Initiator-side controller for the miner. Accepts one job at a
//               time over valid/ready, holds inicio high while the miner works,
//               captures the hash (or gives up after CICLOS_TIMEOUT cycles),
//               checks it against the target and delivers a result record
//               downstream over valid/ready.
// Ports       : clk, reset                       - clock, sync active-high reset
//               trabajo_valido/listo/bloque/target - upstream job channel
//               inicio, bloque_bytes, target      - miner request
//               terminado, hash                   - miner response
//               resultado_valido/listo/hash/ok/timeout - downstream result
//               ocupado                           - not idle
//               cuenta_trabajos                   - results delivered (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module despachador_trabajos
  import despachador_pkg::*;
#(
  parameter int                       ANCHO_TIMEOUT  = 16,
  parameter logic [ANCHO_TIMEOUT-1:0] CICLOS_TIMEOUT = 16'hFFFF,
  parameter int                       CICLOS_PAUSA   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trabajo_valido,
  output logic                    trabajo_listo,
  input  logic [ANCHO_BLOQUE-1:0] trabajo_bloque,
  input  logic [ANCHO_TARGET-1:0] trabajo_target,
  output logic                    inicio,
  output logic [ANCHO_BLOQUE-1:0] bloque_bytes,
  output logic [ANCHO_TARGET-1:0] target,
  input  logic                    terminado,
  input  logic [ANCHO_HASH-1:0]   hash,
  output logic                    resultado_valido,
  input  logic                    resultado_listo,
  output logic [ANCHO_HASH-1:0]   resultado_hash,
  output logic                    resultado_ok,
  output logic                    resultado_timeout,
  output logic                    ocupado,
  output logic [15:0]             cuenta_trabajos
);

  // Pause counter runs 0 .. CICLOS_PAUSA-1
  localparam int ANCHO_PAUSA = (CICLOS_PAUSA > 2) ? $clog2(CICLOS_PAUSA) : 1;
  localparam logic [ANCHO_PAUSA-1:0] c_pausa_ultima = ANCHO_PAUSA'(CICLOS_PAUSA - 1);

  logic [1:0]               estado;
  logic [ANCHO_PAUSA-1:0]   cuenta_pausa;
  logic [ANCHO_TIMEOUT-1:0] cuenta_timeout;
  logic                     vencido;
  logic                     acepta;

  assign acepta = (estado == INACTIVO) && trabajo_valido && trabajo_listo;

  // Outputs decoded straight from the state register, so they are glitch-free
  // and a reset drops them on the very next edge.
  assign inicio  = (estado == ESPERA);
  assign ocupado = (estado != INACTIVO);

  temporizador_trabajo #(
    .ANCHO  (ANCHO_TIMEOUT),
    .LIMITE (CICLOS_TIMEOUT)
  ) u_temporizador (
    .clk         (clk),
    .reset       (reset),
    .limpiar     (acepta),
    .cargar      (1'b0),
    .valor_carga ('0),
    .habilitar   (estado == ESPERA),
    .cuenta      (cuenta_timeout),
    .vencido     (vencido)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado            <= INACTIVO;
      trabajo_listo     <= 1'b0;
      bloque_bytes      <= '0;
      target            <= '0;
      resultado_valido  <= 1'b0;
      resultado_hash    <= '0;
      resultado_ok      <= 1'b0;
      resultado_timeout <= 1'b0;
      cuenta_trabajos   <= '0;
      cuenta_pausa      <= '0;
    end else begin
      case (estado)
        INACTIVO: begin
          if (acepta) begin
            bloque_bytes  <= trabajo_bloque;
            target        <= trabajo_target;
            trabajo_listo <= 1'b0;
            estado        <= ESPERA;
          end else begin
            // Ready comes up one cycle after reset release
            trabajo_listo <= 1'b1;
          end
        end
        ESPERA: begin
          // terminado has priority over an expiring timeout in the same cycle
          if (terminado) begin
            resultado_hash    <= hash;
            resultado_ok      <= hash_cumple(hash, target);
            resultado_timeout <= 1'b0;
            resultado_valido  <= 1'b1;
            estado            <= ENTREGA;
          end else if (vencido) begin
            resultado_hash    <= '0;
            resultado_ok      <= 1'b0;
            resultado_timeout <= 1'b1;
            resultado_valido  <= 1'b1;
            estado            <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (resultado_listo) begin
            resultado_valido <= 1'b0;
            cuenta_trabajos  <= cuenta_trabajos + 16'd1;
            cuenta_pausa     <= '0;
            estado           <= PAUSA;
          end
        end
        PAUSA: begin
          if (cuenta_pausa == c_pausa_ultima) begin
            // Ready is registered, so raise it on the way into INACTIVO
            trabajo_listo <= 1'b1;
            estado        <= INACTIVO;
          end else begin
            cuenta_pausa <= cuenta_pausa + ANCHO_PAUSA'(1);
          end
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

  // cuenta_timeout is only consumed through vencido
  logic unused_ok;
  assign unused_ok = ^cuenta_timeout;

endmodule
`default_nettype wire

// File: tb/tb_despachador_trabajos.sv
`default_nettype none
// ============================================================================
// Module      : tb_despachador_trabajos
// Description : Self-checking bench for despachador_trabajos with a
//               behavioural miner and a job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_despachador_trabajos;

  localparam int c_timeout = 20;
  localparam int c_pausa   = 2;

  logic        clk;
  logic        reset;
  logic        trabajo_valido;
  logic        trabajo_listo;
  logic [95:0] trabajo_bloque;
  logic [7:0]  trabajo_target;
  logic        inicio;
  logic [95:0] bloque_bytes;
  logic [7:0]  target;
  logic        terminado;
  logic [23:0] hash;
  logic        resultado_valido;
  logic        resultado_listo;
  logic [23:0] resultado_hash;
  logic        resultado_ok;
  logic        resultado_timeout;
  logic        ocupado;
  logic [15:0] cuenta_trabajos;

  int n_comparados;
  int n_errores;
  int modelo_cuenta;

  // Miner model configuration
  int          retardo_minero;
  logic [23:0] hash_minero;
  bit          ruido;
  int          ciclos_inicio;

  despachador_trabajos #(
    .ANCHO_TIMEOUT  (16),
    .CICLOS_TIMEOUT (16'd20),
    .CICLOS_PAUSA   (c_pausa)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .trabajo_valido    (trabajo_valido),
    .trabajo_listo     (trabajo_listo),
    .trabajo_bloque    (trabajo_bloque),
    .trabajo_target    (trabajo_target),
    .inicio            (inicio),
    .bloque_bytes      (bloque_bytes),
    .target            (target),
    .terminado         (terminado),
    .hash              (hash),
    .resultado_valido  (resultado_valido),
    .resultado_listo   (resultado_listo),
    .resultado_hash    (resultado_hash),
    .resultado_ok      (resultado_ok),
    .resultado_timeout (resultado_timeout),
    .ocupado           (ocupado),
    .cuenta_trabajos   (cuenta_trabajos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comparar(input string etiqueta, input logic [95:0] obs, input logic [95:0] esp);
    n_comparados++;
    if (obs !== esp) begin
      n_errores++;
      $display("FAIL %s: obtenido=%0h esperado=%0h", etiqueta, obs, esp);
    end
  endtask

  // Miner: raises terminado in the Nth cycle of inicio high; random noise on
  // terminado and hash whenever the result is not meant to be taken.
  initial begin
    terminado     = 1'b0;
    hash          = '0;
    ciclos_inicio = 0;
    forever begin
      @(negedge clk);
      if (inicio === 1'b1) begin
        ciclos_inicio++;
        terminado = (ciclos_inicio >= retardo_minero);
        hash      = terminado ? hash_minero : 24'($urandom);
      end else begin
        ciclos_inicio = 0;
        terminado     = ruido && ($urandom_range(0, 3) == 0);
        hash          = 24'($urandom);
      end
    end
  end

  // One complete job, checked against the job-level model
  task automatic correr_trabajo(input logic [95:0] b, input logic [7:0] t,
                                input int ret, input logic [23:0] h, input int espera_listo);
    logic [23:0] e_hash;
    logic        e_ok;
    logic        e_to;
    int          e_inicio;
    int          n;
    int          guarda;

    retardo_minero = ret;
    hash_minero    = h;
    if (ret > c_timeout) begin
      e_hash = '0; e_ok = 1'b0; e_to = 1'b1; e_inicio = c_timeout;
    end else begin
      e_hash = h; e_ok = (h[23:16] < t); e_to = 1'b0; e_inicio = ret;
    end

    n = 0;
    while (trabajo_listo !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    comparar("listo_disponible", trabajo_listo, 1'b1);

    trabajo_valido = 1'b1;
    trabajo_bloque = b;
    trabajo_target = t;
    @(negedge clk);
    trabajo_valido = 1'b0;
    trabajo_bloque = {$urandom, $urandom, $urandom};
    trabajo_target = 8'($urandom);
    comparar("inicio_latencia", inicio, 1'b1);
    comparar("bloque_bytes", bloque_bytes, b);
    comparar("target", target, t);
    comparar("listo_ocupado", trabajo_listo, 1'b0);
    comparar("ocupado", ocupado, 1'b1);

    n = 0;
    guarda = 0;
    while (resultado_valido !== 1'b1 && guarda < 200) begin
      if (inicio === 1'b1) n++;
      comparar("listo_en_espera", trabajo_listo, 1'b0);
      @(negedge clk);
      guarda++;
    end
    comparar("valido_llega", resultado_valido, 1'b1);
    comparar("ciclos_inicio", n, e_inicio);
    comparar("inicio_baja", inicio, 1'b0);

    resultado_listo = 1'b0;
    for (int i = 0; i <= espera_listo; i++) begin
      comparar("valido_estable", resultado_valido, 1'b1);
      comparar("hash", resultado_hash, e_hash);
      comparar("ok", resultado_ok, e_ok);
      comparar("timeout", resultado_timeout, e_to);
      comparar("listo_entrega", trabajo_listo, 1'b0);
      comparar("inicio_entrega", inicio, 1'b0);
      if (i < espera_listo) @(negedge clk);
    end

    resultado_listo = 1'b1;
    @(negedge clk);
    resultado_listo = 1'b0;
    modelo_cuenta++;
    comparar("valido_cae", resultado_valido, 1'b0);
    comparar("cuenta_trabajos", cuenta_trabajos, 16'(modelo_cuenta));

    n = 0;
    while (trabajo_listo !== 1'b1 && n < 50) begin
      comparar("inicio_pausa", inicio, 1'b0);
      n++;
      @(negedge clk);
    end
    comparar("ciclos_pausa", n, c_pausa);
    comparar("bloque_retiene", bloque_bytes, b);
    comparar("target_retiene", target, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: obtenido=sin_fin esperado=fin");
    $fatal(1);
  end

  initial begin
    logic [7:0]  t;
    logic [23:0] h;

    n_comparados    = 0;
    n_errores       = 0;
    modelo_cuenta   = 0;
    retardo_minero  = 1000;
    hash_minero     = '0;
    ruido           = 1'b0;
    reset           = 1'b1;
    trabajo_valido  = 1'b0;
    trabajo_bloque  = '0;
    trabajo_target  = '0;
    resultado_listo = 1'b0;

    repeat (3) @(negedge clk);
    comparar("rst_inicio", inicio, 1'b0);
    comparar("rst_listo", trabajo_listo, 1'b0);
    comparar("rst_valido", resultado_valido, 1'b0);
    comparar("rst_ocupado", ocupado, 1'b0);
    comparar("rst_cuenta", cuenta_trabajos, 16'd0);
    comparar("rst_bloque", bloque_bytes, 96'd0);
    reset = 1'b0;
    ruido = 1'b1;

    // Nominal, target miss on equality, timeout, simultaneous terminado+timeout
    correr_trabajo(96'h0123_4567_89AB_CDEF_0123_45AB, 8'h40, 10, 24'h3F1234, 7);
    correr_trabajo(96'hDEAD_BEEF_0000_1111_2222_3333, 8'h40, 4, 24'h40FFFF, 2);
    correr_trabajo(96'hCAFE_0000_0000_0000_0000_0001, 8'h80, 1000, 24'h001234, 3);
    correr_trabajo(96'h1111_2222_3333_4444_5555_6666, 8'hFF, c_timeout, 24'hFE0001, 0);

    for (int k = 0; k < 10; k++) begin
      t = 8'($urandom);
      h = {8'(t + 8'($urandom_range(0, 4)) - 8'd2), 16'($urandom)};
      correr_trabajo({$urandom, $urandom, $urandom}, t, $urandom_range(1, 24), h,
                     $urandom_range(0, 7));
    end

    // Reset in the middle of ESPERA
    retardo_minero = 8;
    hash_minero    = 24'h123456;
    trabajo_valido = 1'b1;
    trabajo_bloque = 96'hABCD;
    trabajo_target = 8'h55;
    @(negedge clk);
    trabajo_valido = 1'b0;
    repeat (3) @(negedge clk);
    comparar("pre_rst_inicio", inicio, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelo_cuenta = 0;
    comparar("mid_rst_inicio", inicio, 1'b0);
    comparar("mid_rst_valido", resultado_valido, 1'b0);
    comparar("mid_rst_ocupado", ocupado, 1'b0);
    comparar("mid_rst_cuenta", cuenta_trabajos, 16'd0);
    comparar("mid_rst_bloque", bloque_bytes, 96'd0);
    comparar("mid_rst_target", target, 8'd0);
    repeat (10) begin
      @(negedge clk);
      comparar("post_rst_sin_resultado", resultado_valido, 1'b0);
      comparar("post_rst_inicio", inicio, 1'b0);
    end
    correr_trabajo(96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 8'h10, 6, 24'h0F0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_errores);
    $finish;
  end

endmodule
`default_nettype wire
